// File: rtl/distance_filter_if.sv
// Signal bundle between the echo-timing block (master) and distance_filter (slave).
interface distance_filter_if #(
   parameter int DATA_W = 12
) ();
   logic              trig;
   logic              flush;
   logic [DATA_W-1:0] newest;
   logic [DATA_W-1:0] average;
   logic              avg_valid;
   logic              full;
   logic              rejected;

   modport master (
      output trig, flush, newest,
      input  average, avg_valid, full, rejected
   );

   modport slave (
      input  trig, flush, newest,
      output average, avg_valid, full, rejected
   );
endinterface

// File: rtl/distance_filter.sv
// distance_filter: moving average over the last 2^LOG2_DEPTH distance readings.
// A reading is captured on each falling edge of trig; the running sum is kept
// incrementally by adding the newest sample and dropping the oldest one.
// Optional feature: define OUTLIER_REJECT_EN to discard readings that jump
// more than MAX_JUMP away from the current average (at most REJECT_LIMIT-1
// in a row, so a genuine step change is still tracked).
module distance_filter #(
   parameter int DATA_W       = 12,
   parameter int LOG2_DEPTH   = 3,
   parameter int MAX_JUMP     = 256,
   parameter int REJECT_LIMIT = 3
) (
   input  logic               clk,
   input  logic               reset,
   distance_filter_if.slave   bus
);
   localparam int                DEPTH     = 1 << LOG2_DEPTH;
   localparam int                SUM_W     = DATA_W + LOG2_DEPTH;
   localparam logic [LOG2_DEPTH:0] DEPTH_CNT = (LOG2_DEPTH + 1)'(DEPTH);

   if (LOG2_DEPTH < 1 || LOG2_DEPTH > 6 || MAX_JUMP < 0 || REJECT_LIMIT < 1) begin : g_param_check
      $error("distance_filter: illegal parameter value");
   end

   logic                  last_trig;
   logic                  strobe;
   logic [DATA_W-1:0]     sample_buf [DEPTH];
   logic [LOG2_DEPTH-1:0] wr_ptr;
   logic [LOG2_DEPTH:0]   count;
   logic [SUM_W-1:0]      sum;
   logic [DATA_W-1:0]     oldest;
   logic                  window_full;
   logic                  accept;
   logic                  reject;
   logic                  avg_valid_q;

   assign strobe      = !bus.trig && last_trig;
   assign oldest      = sample_buf[wr_ptr];
   assign window_full = (count == DEPTH_CNT);

`ifdef OUTLIER_REJECT_EN
   localparam int                RC_W      = (REJECT_LIMIT > 2) ? $clog2(REJECT_LIMIT) : 1;
   localparam logic [RC_W-1:0]   REJ_LAST  = RC_W'(REJECT_LIMIT - 1);
   localparam logic [DATA_W-1:0] MAX_JUMP_W = DATA_W'(MAX_JUMP);

   logic [RC_W-1:0]   rej_cnt;
   logic [DATA_W-1:0] diff;
   logic              is_outlier;
   logic              rejected_q;

   // Unsigned magnitude of the jump from the current average.
   always_comb begin
      diff = (bus.newest >= bus.average) ? (bus.newest - bus.average)
                                         : (bus.average - bus.newest);
   end

   assign is_outlier = window_full && (diff > MAX_JUMP_W);
   assign reject     = strobe && !bus.flush && is_outlier && (rej_cnt != REJ_LAST);
   assign accept     = strobe && !bus.flush && !reject;

   // Consecutive-rejection counter; any accepted sample (forced or in-range) clears it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rej_cnt    <= '0;
         rejected_q <= 1'b0;
      end else begin
         rejected_q <= reject;
         if (bus.flush || accept)
            rej_cnt <= '0;
         else if (reject)
            rej_cnt <= rej_cnt + 1'b1;
      end
   end

   assign bus.rejected = rejected_q;
`else
   assign reject       = 1'b0;
   assign accept       = strobe && !bus.flush;
   assign bus.rejected = reject;
`endif

   // Trigger history for falling-edge detection; tracks trig even during flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         last_trig <= 1'b0;
      else
         last_trig <= bus.trig;
   end

   // Ring buffer write; stale entries after flush are masked by count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++)
            sample_buf[i] <= '0;
      end else if (accept) begin
         sample_buf[wr_ptr] <= bus.newest;
      end
   end

   // Pointer, fill count, running sum and the update strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr      <= '0;
         count       <= '0;
         sum         <= '0;
         avg_valid_q <= 1'b0;
      end else begin
         avg_valid_q <= accept;
         if (bus.flush) begin
            wr_ptr <= '0;
            count  <= '0;
            sum    <= '0;
         end else if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (!window_full)
               count <= count + 1'b1;
            sum <= sum + SUM_W'(bus.newest) - (window_full ? SUM_W'(oldest) : '0);
         end
      end
   end

   assign bus.average   = sum[SUM_W-1:LOG2_DEPTH];
   assign bus.full      = window_full;
   assign bus.avg_valid = avg_valid_q;
endmodule

// File: tb/tb_distance_filter.sv
// Directed bench for distance_filter: table-driven strobe vectors plus
// hand-written sequences for the outlier burst and a mid-window reset.
`timescale 1ns/1ps
module tb_distance_filter;
   localparam int DATA_W = 12;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   distance_filter_if #(.DATA_W(DATA_W)) bus ();

   distance_filter #(
      .DATA_W(DATA_W), .LOG2_DEPTH(3), .MAX_JUMP(256), .REJECT_LIMIT(3)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   typedef struct {
      int newest;
      bit flush;
      int exp_avg;
      bit exp_full;
      bit exp_valid;
      bit exp_rej;
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;
   vec_t tab_a[$];
   vec_t tab_b[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One full trigger period: raise trig, drop it (strobe cycle), then check the
   // registered result one edge later.
   task automatic strobe_chk(input string tag, input int v, input bit f,
                             input int ea, input bit ef, input bit ev, input bit er);
      @(posedge clk); #1;
      check({tag, " pulse_cleared_valid"}, 32'(bus.avg_valid), 32'd0);
      check({tag, " pulse_cleared_rej"},   32'(bus.rejected),  32'd0);
      bus.trig   = 1'b1;
      bus.newest = DATA_W'(v);
      @(posedge clk); #1;
      bus.trig  = 1'b0;
      bus.flush = f;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      check({tag, " average"},   32'(bus.average),   32'(ea));
      check({tag, " full"},      32'(bus.full),      32'(ef));
      check({tag, " avg_valid"}, 32'(bus.avg_valid), 32'(ev));
      check({tag, " rejected"},  32'(bus.rejected),  32'(er));
   endtask

   initial begin
      bus.trig   = 1'b0;
      bus.flush  = 1'b0;
      bus.newest = '0;

      // Warm-up with 100: averages biased low until the 8th sample.
      tab_a.push_back('{100, 1'b0,  12, 1'b0, 1'b1, 1'b0});
      tab_a.push_back('{100, 1'b0,  25, 1'b0, 1'b1, 1'b0});
      tab_a.push_back('{100, 1'b0,  37, 1'b0, 1'b1, 1'b0});
      tab_a.push_back('{100, 1'b0,  50, 1'b0, 1'b1, 1'b0});
      tab_a.push_back('{100, 1'b0,  62, 1'b0, 1'b1, 1'b0});
      tab_a.push_back('{100, 1'b0,  75, 1'b0, 1'b1, 1'b0});
      tab_a.push_back('{100, 1'b0,  87, 1'b0, 1'b1, 1'b0});
      tab_a.push_back('{100, 1'b0, 100, 1'b1, 1'b1, 1'b0});

      // Flush-with-strobe, ramp 0..190, flush, 5 x 50, flush-with-strobe, 80.
      tab_b.push_back('{0, 1'b1, 0, 1'b0, 1'b0, 1'b0});
      tab_b.push_back('{  0, 1'b0,   0, 1'b0, 1'b1, 1'b0});
      tab_b.push_back('{ 10, 1'b0,   1, 1'b0, 1'b1, 1'b0});
      tab_b.push_back('{ 20, 1'b0,   3, 1'b0, 1'b1, 1'b0});
      tab_b.push_back('{ 30, 1'b0,   7, 1'b0, 1'b1, 1'b0});
      tab_b.push_back('{ 40, 1'b0,  12, 1'b0, 1'b1, 1'b0});
      tab_b.push_back('{ 50, 1'b0,  18, 1'b0, 1'b1, 1'b0});
      tab_b.push_back('{ 60, 1'b0,  26, 1'b0, 1'b1, 1'b0});
      tab_b.push_back('{ 70, 1'b0,  35, 1'b1, 1'b1, 1'b0});
      tab_b.push_back('{ 80, 1'b0,  45, 1'b1, 1'b1, 1'b0});
      tab_b.push_back('{ 90, 1'b0,  55, 1'b1, 1'b1, 1'b0});
      tab_b.push_back('{100, 1'b0,  65, 1'b1, 1'b1, 1'b0});
      tab_b.push_back('{110, 1'b0,  75, 1'b1, 1'b1, 1'b0});
      tab_b.push_back('{120, 1'b0,  85, 1'b1, 1'b1, 1'b0});
      tab_b.push_back('{130, 1'b0,  95, 1'b1, 1'b1, 1'b0});
      tab_b.push_back('{140, 1'b0, 105, 1'b1, 1'b1, 1'b0});
      tab_b.push_back('{150, 1'b0, 115, 1'b1, 1'b1, 1'b0});
      tab_b.push_back('{160, 1'b0, 125, 1'b1, 1'b1, 1'b0});
      tab_b.push_back('{170, 1'b0, 135, 1'b1, 1'b1, 1'b0});
      tab_b.push_back('{180, 1'b0, 145, 1'b1, 1'b1, 1'b0});
      tab_b.push_back('{190, 1'b0, 155, 1'b1, 1'b1, 1'b0});
      tab_b.push_back('{  0, 1'b1,   0, 1'b0, 1'b0, 1'b0});
      tab_b.push_back('{ 50, 1'b0,   6, 1'b0, 1'b1, 1'b0});
      tab_b.push_back('{ 50, 1'b0,  12, 1'b0, 1'b1, 1'b0});
      tab_b.push_back('{ 50, 1'b0,  18, 1'b0, 1'b1, 1'b0});
      tab_b.push_back('{ 50, 1'b0,  25, 1'b0, 1'b1, 1'b0});
      tab_b.push_back('{ 50, 1'b0,  31, 1'b0, 1'b1, 1'b0});
      tab_b.push_back('{ 77, 1'b1,   0, 1'b0, 1'b0, 1'b0});
      tab_b.push_back('{ 80, 1'b0,  10, 1'b0, 1'b1, 1'b0});

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("reset average",   32'(bus.average),   32'd0);
      check("reset full",      32'(bus.full),      32'd0);
      check("reset avg_valid", 32'(bus.avg_valid), 32'd0);
      check("reset rejected",  32'(bus.rejected),  32'd0);
      reset = 1'b1;

      foreach (tab_a[i])
         strobe_chk($sformatf("fill[%0d]", i), tab_a[i].newest, tab_a[i].flush,
                    tab_a[i].exp_avg, tab_a[i].exp_full, tab_a[i].exp_valid, tab_a[i].exp_rej);

`ifdef OUTLIER_REJECT_EN
      strobe_chk("jump1", 900, 1'b0, 100, 1'b1, 1'b0, 1'b1);
      strobe_chk("jump2", 900, 1'b0, 100, 1'b1, 1'b0, 1'b1);
      strobe_chk("jump3", 900, 1'b0, 200, 1'b1, 1'b1, 1'b0);
`else
      strobe_chk("jump1", 900, 1'b0, 200, 1'b1, 1'b1, 1'b0);
`endif

      foreach (tab_b[i])
         strobe_chk($sformatf("seq[%0d]", i), tab_b[i].newest, tab_b[i].flush,
                    tab_b[i].exp_avg, tab_b[i].exp_full, tab_b[i].exp_valid, tab_b[i].exp_rej);

      // Mid-window asynchronous reset, then refill from sample 1.
      strobe_chk("pre_rst_flush", 0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 5; k++)
         strobe_chk($sformatf("pre_rst[%0d]", k), 40, 1'b0, 5 * k, 1'b0, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("async_rst average",   32'(bus.average),   32'd0);
      check("async_rst full",      32'(bus.full),      32'd0);
      check("async_rst avg_valid", 32'(bus.avg_valid), 32'd0);
      check("async_rst rejected",  32'(bus.rejected),  32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      for (int k = 1; k <= 8; k++)
         strobe_chk($sformatf("post_rst[%0d]", k), 40, 1'b0, 5 * k, (k == 8), 1'b1, 1'b0);

      @(posedge clk); #1;
      check("final avg_valid low", 32'(bus.avg_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
